// File: rtl/arb_mux_n_1.sv
// arb_mux_n_1: registered N:1 multiplexer with per-channel valid/ready.
// Fixed-select (mode=0) or round-robin (mode=1) arbitration feeds a single
// output register stage that may drain and refill in the same cycle.
module arb_mux_n_1 #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned N     = 4,
  parameter int unsigned SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_chan,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [WIDTH-1:0] r_out_data;
  logic [SELW-1:0]  r_out_chan;
  logic             r_out_valid;
  logic [SELW-1:0]  r_ptr;

  logic             w_load;
  logic             w_grant_valid;
  logic [SELW-1:0]  w_grant;
  logic [WIDTH-1:0] w_grant_data;

  assign w_load    = !r_out_valid || out_ready;
  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;
  assign out_valid = r_out_valid;

  // Grant selection: fixed channel from sel, or first valid channel after r_ptr.
  always_comb begin
    logic [SELW-1:0] v_idx;
    w_grant_valid = 1'b0;
    w_grant       = '0;
    v_idx         = '0;
    if (!mode) begin
      if (32'(sel) < N) begin
        if (in_valid[sel]) begin
          w_grant_valid = 1'b1;
          w_grant       = sel;
        end
      end
    end else begin
      for (int unsigned k = 1; k <= N; k++) begin
        v_idx = SELW'((32'(r_ptr) + k) % N);
        if (!w_grant_valid && in_valid[v_idx]) begin
          w_grant_valid = 1'b1;
          w_grant       = v_idx;
        end
      end
    end
  end

  // Data of the granted channel.
  always_comb begin
    w_grant_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (SELW'(i) == w_grant) w_grant_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Accept strobe: one-hot on the granted channel when the register can load.
  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!reset && w_load && w_grant_valid && (SELW'(i) == w_grant)) in_ready[i] = 1'b1;
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_out_valid <= 1'b0;
      r_ptr       <= SELW'(N - 1);
    end else if (w_load) begin
      if (w_grant_valid) begin
        r_out_data  <= w_grant_data;
        r_out_chan  <= w_grant;
        r_out_valid <= 1'b1;
        r_ptr       <= w_grant;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux_n_1.sv
// Directed, table-driven bench for arb_mux_n_1 with N=4, WIDTH=8.
module tb_arb_mux_n_1;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned N     = 4;
  localparam int unsigned SELW  = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic               mode;
  logic [SELW-1:0]    sel;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_chan;
  logic               out_valid;
  logic               out_ready;

  int errors = 0;
  int checks = 0;

  arb_mux_n_1 #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            rst;
    logic            md;
    logic [SELW-1:0] s;
    logic [N-1:0]    iv;
    logic            ordy;
    logic [N-1:0]    e_ir;
    logic            e_ov;
    logic [SELW-1:0] e_ch;
    logic [WIDTH-1:0] e_d;
  } vec_t;

  vec_t vecs[25];

  function automatic vec_t mk(logic rst, logic md, logic [SELW-1:0] s, logic [N-1:0] iv,
                              logic ordy, logic [N-1:0] e_ir, logic e_ov,
                              logic [SELW-1:0] e_ch, logic [WIDTH-1:0] e_d);
    vec_t v;
    v.rst = rst; v.md = md; v.s = s; v.iv = iv; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_ch = e_ch; v.e_d = e_d;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply one cycle: drive at negedge, check in_ready before the edge, outputs after it.
  task automatic step(input string tag, input logic rst, input logic md, input logic [SELW-1:0] s,
                      input logic [N-1:0] iv, input logic ordy, input logic [N-1:0] e_ir,
                      input logic e_ov, input logic [SELW-1:0] e_ch, input logic [WIDTH-1:0] e_d);
    @(negedge clk);
    reset = rst; mode = md; sel = s; in_valid = iv; out_ready = ordy;
    #1;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(e_ir));
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(e_ov));
    chk({tag, ".out_chan"}, 64'(out_chan), 64'(e_ch));
    chk({tag, ".out_data"}, 64'(out_data), 64'(e_d));
  endtask

  initial begin
    int cnt[N];
    reset = 1'b1; mode = 1'b1; sel = '0; in_valid = '1; out_ready = 1'b1;
    in_data = {8'h44, 8'h33, 8'h22, 8'h11};

    //            rst  md  sel   valid    ordy  in_ready  ov  chan  data
    vecs[0]  = mk(1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00);
    vecs[1]  = mk(1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00);
    // round-robin fairness, first grant goes to channel 0
    vecs[2]  = mk(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11);
    vecs[3]  = mk(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h22);
    vecs[4]  = mk(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h33);
    vecs[5]  = mk(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h44);
    vecs[6]  = mk(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11);
    vecs[7]  = mk(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h22);
    vecs[8]  = mk(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h33);
    vecs[9]  = mk(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h44);
    // sparse round-robin: channels 1 and 3
    vecs[10] = mk(1'b0, 1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h22);
    vecs[11] = mk(1'b0, 1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h44);
    vecs[12] = mk(1'b0, 1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h22);
    vecs[13] = mk(1'b0, 1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h44);
    // fixed mode sel=2, then drop channel 2
    vecs[14] = mk(1'b0, 1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h33);
    vecs[15] = mk(1'b0, 1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h33);
    vecs[16] = mk(1'b0, 1'b0, 2'd2, 4'b1011, 1'b1, 4'b0000, 1'b0, 2'd2, 8'h33);
    // backpressure: load, stall 3 cycles, then drain and refill together
    vecs[17] = mk(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h44);
    vecs[18] = mk(1'b0, 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3, 8'h44);
    vecs[19] = mk(1'b0, 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3, 8'h44);
    vecs[20] = mk(1'b0, 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3, 8'h44);
    vecs[21] = mk(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11);
    // mid-stream reset during a stall, then next grant must be channel 0 again
    vecs[22] = mk(1'b0, 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h11);
    vecs[23] = mk(1'b1, 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00);
    vecs[24] = mk(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11);

    for (int i = 0; i < 25; i++) begin
      step($sformatf("v%0d", i), vecs[i].rst, vecs[i].md, vecs[i].s, vecs[i].iv, vecs[i].ordy,
           vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_ch, vecs[i].e_d);
    end

    // Held word survives mode/sel changes during a stall; new sel applies on release.
    step("hold0", 1'b0, 1'b0, 2'd1, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h11);
    step("hold1", 1'b0, 1'b0, 2'd1, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h11);
    step("sel1",  1'b0, 1'b0, 2'd1, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h22);

    // New data pattern, fixed mode on channel 3.
    @(negedge clk);
    in_data = {8'hA5, 8'h5A, 8'hC3, 8'h3C};
    step("newd", 1'b0, 1'b0, 2'd3, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA5);

    // Fairness over 8 cycles: each channel accepted exactly twice.
    for (int c = 0; c < N; c++) cnt[c] = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      reset = 1'b0; mode = 1'b1; in_valid = '1; out_ready = 1'b1;
      #1;
      for (int c = 0; c < N; c++) if (in_ready[c]) cnt[c]++;
      @(posedge clk);
    end
    for (int c = 0; c < N; c++) chk($sformatf("fair_ch%0d", c), 64'(cnt[c]), 64'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
